sipo_frame_loader: RTL and testbench
====================================

// Module: sipo_frame_loader
// PURPOSE
//   Serial-to-parallel front end for the PIPO register stage. Collects WIDTH
//   qualified serial bits into a word, then presents the word with a one-cycle
//   load strobe that drives the PIPO's x/load inputs directly.
//   Also tracks partial-frame state, abort, and a completed-frame count.
// PARAMETERS
//   WIDTH      4   bits per parallel word (>=2)
//   MSB_FIRST  1   1: first serial bit lands in word_out[WIDTH-1]; 0: in word_out[0]
//   FCNT_W     8   width of completed-frame counter
// PORTS
//   clk        in   1          single clock, all logic on posedge
//   rst        in   1          synchronous, active-high reset
//   sin        in   1          serial data bit
//   sin_valid  in   1          sin sampled only when 1
//   abort      in   1          discard the partial frame (synchronous)
//   word_out   out  WIDTH      assembled word; stable between load pulses
//   load       out  1          1-cycle strobe: word_out is new and valid
//   busy       out  1          partial frame in progress (bit_cnt != 0)
//   bit_cnt    out  clog2(WIDTH+1)  bits collected in the current frame
//   frame_cnt  out  FCNT_W     completed (loaded) frames; wraps to 0
//   par_err    out  1          parity error strobe (see CONFIGURATION)
// BEHAVIOUR
//   Reset: word_out=0, load=0, busy=0, bit_cnt=0, frame_cnt=0, par_err=0,
//     state=IDLE. Reset wins over every other input, including mid-frame.
//   FSM IDLE -> SHIFT -> LOAD. All outputs are registered.
//   IDLE:  sin_valid=1 -> capture bit, bit_cnt=1, go to SHIFT.
//   SHIFT: each sin_valid=1 shifts one bit in, bit_cnt+1. Gaps (sin_valid=0)
//     hold all state. On capture of bit number FRAME_BITS, go to LOAD.
//   LOAD (exactly 1 cycle): load=1, word_out=assembled word, frame_cnt+1
//     (mod 2^FCNT_W), bit_cnt=0.
//     sin_valid=1 in LOAD starts the next frame: bit_cnt=1, go to SHIFT.
//     This gives back-to-back frames with no dropped bit.
//     Otherwise go to IDLE.
//   Latency: load rises on the clock edge after the last frame bit is
//     sampled. The downstream PIPO captures word_out on the following edge.
//   abort=1 in SHIFT: clear shift reg and bit_cnt, go to IDLE, no load.
//     abort in IDLE/LOAD: no effect on the LOAD outputs.
//     abort overrides a simultaneous sin_valid (that bit is dropped).
//   word_out changes only in LOAD; abort/reset are the only other writers.
//   busy = (state==SHIFT).
// CONFIGURATION
//   PARITY_CHECK_EN defined:
//     FRAME_BITS = WIDTH+1; the final serial bit is an even-parity bit
//     over the data bits.
//     Parity ok: normal LOAD.
//     Parity mismatch: one LOAD-state cycle with par_err=1, load=0;
//     word_out and frame_cnt are unchanged.
//   Undefined: FRAME_BITS = WIDTH; par_err tied to 0.
// STRUCTURE
//   Shared package sipo_pkg:
//     - state encodings IDLE/SHIFT/LOAD
//     - FRAME_BITS derivation
//     - clog2 helper for the bit_cnt width
//   One sub-module: sipo_shift_core (WIDTH, MSB_FIRST).
//     - shift register with shift_en/clear ports
//     - owns the bit counter and the done flag
//   The top level holds the FSM, the frame counter, and the parity check.
// TESTING (WIDTH=4, MSB_FIRST=1 unless noted)
//   1 Reset, then serial bits 1,0,1,1 on consecutive cycles.
//     -> next cycle: load=1 for exactly 1 cycle, word_out=4'b1011, frame_cnt=1.
//   2 Frames 1011 and 1111 back-to-back, second frame's first bit in LOAD.
//     -> two load pulses 4 cycles apart; word_out 1011 then 1111; frame_cnt=2.
//   3 Bits 1,0 / sin_valid low 3 cycles / 1,1.
//     -> busy=1 and bit_cnt=2 through the gap; load once; word_out=1011.
//   4 Bits 1,1 then abort, then 0,1,1,0.
//     -> no load at abort; next load has word_out=4'b0110.
//   5 rst=1 after 3 bits of a frame.
//     -> all outputs return to reset values; next full frame loads correctly.
//   6 MSB_FIRST=0, bits 1,0,1,1 -> word_out=4'b1101.
//   7 PARITY_CHECK_EN: 1,0,1,1,parity 1 -> load, word_out=1011.
//     Same data with parity 0 -> par_err pulse, no load, word_out unchanged.
//   8 255 frames followed by one more -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared FSM encoding, frame length and width helper; PARITY_CHECK_EN adds a trailing parity bit
package sipo_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd2} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int frame_bits(input int width);
`ifdef PARITY_CHECK_EN
        return width + 1;
`else
        return width;
`endif
    endfunction
endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: frame shift register with bit counter and last-bit flag
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sin,
    input  logic                          shift_en,
    input  logic                          clear,
    output logic [clog2(WIDTH + 1)-1:0]   bit_cnt,
    output logic                          done,
    output logic [frame_bits(WIDTH)-1:0]  frame
);
    localparam int NBITS = frame_bits(WIDTH);
    localparam int CW    = clog2(WIDTH + 1);

    logic [NBITS-1:0] sr;

    // register contents after the bit being sampled now; done marks the frame's last bit
    always_comb begin
        frame = MSB_FIRST ? {sr[NBITS-2:0], sin} : {sin, sr[NBITS-1:1]};
        done  = shift_en && !clear && bit_cnt == CW'(NBITS - 1);
    end

    // shift on qualified bits, restart the count once a frame completes
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            sr      <= frame;
            bit_cnt <= done ? '0 : bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sipo_frame_loader.sv
// sipo_frame_loader: serial-to-parallel loader with one-cycle load strobe; PARITY_CHECK_EN enables even parity
module sipo_frame_loader
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int FCNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sin,
    input  logic                        sin_valid,
    input  logic                        abort,
    output logic [WIDTH-1:0]            word_out,
    output logic                        load,
    output logic                        busy,
    output logic [clog2(WIDTH + 1)-1:0] bit_cnt,
    output logic [FCNT_W-1:0]           frame_cnt,
    output logic                        par_err
);
    localparam int NBITS = frame_bits(WIDTH);

    state_t           state, next;
    logic             shift_en, done, par_ok;
    logic [NBITS-1:0] frame;
    logic [WIDTH-1:0] data;

    assign shift_en = sin_valid && !abort;

    sipo_shift_core #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_core (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .shift_en (shift_en),
        .clear    (abort),
        .bit_cnt  (bit_cnt),
        .done     (done),
        .frame    (frame)
    );

`ifdef PARITY_CHECK_EN
    assign data   = MSB_FIRST ? frame[NBITS-1 -: WIDTH] : frame[WIDTH-1:0];
    assign par_ok = ~^frame;
`else
    assign data   = frame;
    assign par_ok = 1'b1;
`endif

    // abort beats everything, a completed frame enters LOAD, any other bit keeps or starts a frame
    always_comb begin
        next = IDLE;
        next = abort ? IDLE : done ? LOAD : (shift_en || state == SHIFT) ? SHIFT : IDLE;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // registered outputs; word_out and frame_cnt move only on a good frame
    always_ff @(posedge clk) begin
        if (rst) begin
            word_out  <= '0;
            load      <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
            par_err   <= 1'b0;
        end else begin
            load    <= done && par_ok;
            par_err <= done && !par_ok;
            busy    <= next == SHIFT;
            if (done && par_ok) begin
                word_out  <= data;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sipo_frame_loader.sv
// tb_sipo_frame_loader: directed and random checks of both bit orders against a bit-queue model
module tb_sipo_frame_loader;
    localparam int W = 4;
`ifdef PARITY_CHECK_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic clk = 1'b0;
    logic rst, sin, sin_valid, abort;
    logic [W-1:0] word_m, word_l;
    logic load_m, load_l, busy_m, busy_l, perr_m, perr_l;
    logic [2:0] cnt_m, cnt_l;
    logic [7:0] fcnt_m, fcnt_l;

    int total = 0;
    int bad = 0;
    bit q[$];
    logic [W-1:0] e_wm, e_wl;
    logic e_load, e_perr;
    int e_fcnt;

    always #5 clk = ~clk;

    sipo_frame_loader #(.WIDTH(W), .MSB_FIRST(1'b1), .FCNT_W(8)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .abort(abort),
        .word_out(word_m), .load(load_m), .busy(busy_m), .bit_cnt(cnt_m),
        .frame_cnt(fcnt_m), .par_err(perr_m)
    );

    sipo_frame_loader #(.WIDTH(W), .MSB_FIRST(1'b0), .FCNT_W(8)) dut_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .abort(abort),
        .word_out(word_l), .load(load_l), .busy(busy_l), .bit_cnt(cnt_l),
        .frame_cnt(fcnt_l), .par_err(perr_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // collect bits into a queue; a full frame becomes words in both orders plus a parity verdict
    task automatic model(input logic r, input logic sv, input logic s, input logic ab);
        int ones;
        bit ok;
        logic [W-1:0] wm, wl;
        e_load = 1'b0;
        e_perr = 1'b0;
        if (r) begin
            q.delete();
            e_wm = '0;
            e_wl = '0;
            e_fcnt = 0;
        end else if (ab) begin
            q.delete();
        end else if (sv) begin
            q.push_back(s);
            if (q.size() == FB) begin
                ones = 0;
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = q[i];
                    wl[i] = q[i];
                    ones += int'(q[i]);
                end
                ok = 1'b1;
                if (FB > W) ok = (q[FB-1] == ones[0]);
                if (ok) begin
                    e_load = 1'b1;
                    e_wm = wm;
                    e_wl = wl;
                    e_fcnt = (e_fcnt + 1) % 256;
                end else begin
                    e_perr = 1'b1;
                end
                q.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("load", 32'(load_m), 32'(e_load));
        chk("load_l", 32'(load_l), 32'(e_load));
        chk("word", 32'(word_m), 32'(e_wm));
        chk("word_l", 32'(word_l), 32'(e_wl));
        chk("fcnt", 32'(fcnt_m), 32'(e_fcnt));
        chk("fcnt_l", 32'(fcnt_l), 32'(e_fcnt));
        chk("busy", 32'(busy_m), 32'(q.size() != 0));
        chk("busy_l", 32'(busy_l), 32'(q.size() != 0));
        chk("cnt", 32'(cnt_m), 32'(q.size()));
        chk("cnt_l", 32'(cnt_l), 32'(q.size()));
        chk("perr", 32'(perr_m), 32'(e_perr));
        chk("perr_l", 32'(perr_l), 32'(e_perr));
    endtask

    task automatic step(input logic r, input logic sv, input logic s, input logic ab);
        rst = r;
        sin_valid = sv;
        sin = s;
        abort = ab;
        @(posedge clk);
        model(r, sv, s, ab);
        @(negedge clk);
        check_all();
    endtask

    task automatic bit_in(input logic s);
        step(1'b0, 1'b1, s, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic parity(input logic [W-1:0] w);
        if (FB > W) bit_in(^w);
    endtask

    task automatic frame(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) bit_in(w[i]);
        parity(w);
    endtask

    initial begin
        logic [W-1:0] rw;
        logic r, sv, s, ab;
        reset();
        chk("rst_word", 32'(word_m), 32'h0);
        chk("rst_load", 32'(load_m), 32'h0);
        chk("rst_fcnt", 32'(fcnt_m), 32'h0);

        frame(4'b1011);
        chk("t1_load", 32'(load_m), 32'h1);
        chk("t1_word", 32'(word_m), 32'hb);
        chk("t1_fcnt", 32'(fcnt_m), 32'h1);
        idle();
        chk("t1_pulse", 32'(load_m), 32'h0);

        reset();
        frame(4'b1011);
        frame(4'b1111);
        chk("t2_load", 32'(load_m), 32'h1);
        chk("t2_word", 32'(word_m), 32'hf);
        chk("t2_fcnt", 32'(fcnt_m), 32'h2);

        reset();
        bit_in(1'b1);
        bit_in(1'b0);
        repeat (3) begin
            idle();
            chk("t3_busy", 32'(busy_m), 32'h1);
            chk("t3_cnt", 32'(cnt_m), 32'h2);
        end
        bit_in(1'b1);
        bit_in(1'b1);
        parity(4'b1011);
        chk("t3_load", 32'(load_m), 32'h1);
        chk("t3_word", 32'(word_m), 32'hb);

        reset();
        bit_in(1'b1);
        bit_in(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_noload", 32'(load_m), 32'h0);
        chk("t4_cnt", 32'(cnt_m), 32'h0);
        frame(4'b0110);
        chk("t4_load", 32'(load_m), 32'h1);
        chk("t4_word", 32'(word_m), 32'h6);

        reset();
        frame(4'b1011);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        reset();
        chk("t5_word", 32'(word_m), 32'h0);
        chk("t5_busy", 32'(busy_m), 32'h0);
        chk("t5_cnt", 32'(cnt_m), 32'h0);
        chk("t5_fcnt", 32'(fcnt_m), 32'h0);
        frame(4'b0101);
        chk("t5_word2", 32'(word_m), 32'h5);

        reset();
        frame(4'b1011);
        chk("t6_word_l", 32'(word_l), 32'hd);

`ifdef PARITY_CHECK_EN
        reset();
        frame(4'b1011);
        chk("t7_load", 32'(load_m), 32'h1);
        chk("t7_word", 32'(word_m), 32'hb);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        chk("t7_perr", 32'(perr_m), 32'h1);
        chk("t7_noload", 32'(load_m), 32'h0);
        chk("t7_hold", 32'(word_m), 32'hb);
        chk("t7_fcnt", 32'(fcnt_m), 32'h1);
`endif

        reset();
        repeat (255) begin
            rw = W'($urandom);
            frame(rw);
        end
        chk("t8_255", 32'(fcnt_m), 32'd255);
        rw = W'($urandom);
        frame(rw);
        chk("t8_wrap", 32'(fcnt_m), 32'h0);
        chk("t8_load", 32'(load_m), 32'h1);

        reset();
        repeat (3000) begin
            r = ($urandom_range(0, 199) == 0);
            sv = ($urandom_range(0, 9) < 7);
            s = 1'($urandom);
            ab = (q.size() != 0) && ($urandom_range(0, 19) == 0);
            step(r, sv, s, ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
